ni_flit_rx: RTL and testbench

Network-interface receiver on the local side of a router output port. It accepts 34-bit flits over the router's req/ack link, buffers them in a small FIFO and checks packet framing and destination. Valid packets are delivered as a payload stream to the attached core with valid/ready, sop and eop markers. It also counts delivered packets and framing errors.

---
 rtl/ni_flit_rx.sv | 192 +++++++++++++++++++
 tb/tb_ni_flit_rx.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ni_flit_rx.sv
`default_nettype none
// ============================================================================
// Module      : ni_flit_rx
// Description : Network-interface flit receiver. Buffers 34-bit flits from the
//               router req/ack link in a FWFT FIFO, checks packet framing and
//               destination, and delivers payload words with sop/eop markers.
//               Counts delivered packets and framing errors.
// Revision    : 1.0 - initial release
// ============================================================================
module ni_flit_rx #(
    parameter int         DEPTH   = 4,
    parameter logic [3:0] NODE_ID = 4'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [33:0] in_flit,
    input  logic        in_req,
    output logic        out_ack,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_sop,
    output logic        out_eop,
    output logic [3:0]  out_src,
    output logic [15:0] pkt_cnt,
    output logic [7:0]  err_cnt,
    output logic        err
);

    localparam int              c_aw    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int              c_cw    = c_aw + 1;
    localparam logic [c_cw-1:0] c_depth = c_cw'(DEPTH);

    localparam logic [1:0] c_ty_body   = 2'b00;
    localparam logic [1:0] c_ty_tail   = 2'b01;
    localparam logic [1:0] c_ty_head   = 2'b10;
    localparam logic [1:0] c_ty_single = 2'b11;

    typedef enum logic [1:0] {
        c_st_idle = 2'd0,
        c_st_pkt  = 2'd1,
        c_st_drop = 2'd2
    } state_t;

    logic [33:0]     r_mem [DEPTH];
    logic [c_aw-1:0] r_wr_ptr;
    logic [c_aw-1:0] r_rd_ptr;
    logic [c_cw-1:0] r_count;
    state_t          r_state;
    logic [3:0]      r_src;
    logic [15:0]     r_pkt_cnt;
    logic [7:0]      r_err_cnt;

    logic            w_push;
    logic            w_pop;
    logic            w_have;
    logic [33:0]     w_head;
    logic [1:0]      w_type;
    logic            w_hit;
    state_t          w_state_nxt;
    logic            w_valid;
    logic [31:0]     w_data;
    logic            w_sop;
    logic            w_eop;
    logic            w_err;
    logic            w_take_src;

    // Acceptance depends only on registered occupancy; a same-cycle pop never frees a slot early.
    assign out_ack = !rst && (r_count < c_depth);
    assign w_push  = in_req && out_ack;
    assign w_have  = !rst && (r_count != '0);
    assign w_head  = r_mem[r_rd_ptr];
    assign w_type  = w_head[33:32];
    assign w_hit   = (w_head[31:28] == NODE_ID);

    // FIFO storage; reads are qualified by occupancy so entries need no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_flit;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Framing classification of the FIFO head flit: deliver, discard or close a broken packet.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_valid     = 1'b0;
        w_data      = '0;
        w_sop       = 1'b0;
        w_eop       = 1'b0;
        w_err       = 1'b0;
        w_take_src  = 1'b0;
        if (w_have) begin
            case (r_state)
                c_st_pkt: begin
                    w_valid = 1'b1;
                    if (w_type == c_ty_body || w_type == c_ty_tail) begin
                        w_data = w_head[31:0];
                        w_eop  = (w_type == c_ty_tail);
                        if (out_ready) begin
                            w_pop = 1'b1;
                            if (w_type == c_ty_tail) w_state_nxt = c_st_idle;
                        end
                    end else begin
                        // Missing tail: emit a zero closing word; the new head stays queued
                        // and is classified again from IDLE.
                        w_eop = 1'b1;
                        if (out_ready) begin
                            w_err       = 1'b1;
                            w_state_nxt = c_st_idle;
                        end
                    end
                end
                default: begin
                    // IDLE and DROP share head handling; DROP suppresses error reporting.
                    case (w_type)
                        c_ty_head, c_ty_single: begin
                            if (w_hit) begin
                                w_valid = 1'b1;
                                w_data  = w_head[31:0];
                                w_sop   = 1'b1;
                                w_eop   = (w_type == c_ty_single);
                                if (out_ready) begin
                                    w_pop       = 1'b1;
                                    w_take_src  = 1'b1;
                                    w_state_nxt = (w_type == c_ty_single) ? c_st_idle : c_st_pkt;
                                end
                            end else begin
                                w_pop       = 1'b1;
                                w_err       = (r_state == c_st_idle);
                                w_state_nxt = (w_type == c_ty_head) ? c_st_drop : c_st_idle;
                            end
                        end
                        c_ty_body: begin
                            w_pop = 1'b1;
                            w_err = (r_state == c_st_idle);
                        end
                        default: begin
                            w_pop       = 1'b1;
                            w_err       = (r_state == c_st_idle);
                            w_state_nxt = c_st_idle;
                        end
                    endcase
                end
            endcase
        end
    end

    // Framing state, packet source latch and statistics counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_st_idle;
            r_src     <= '0;
            r_pkt_cnt <= '0;
            r_err_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_take_src) r_src <= w_head[27:24];
            if (w_valid && out_ready && w_eop) r_pkt_cnt <= r_pkt_cnt + 1'b1;
            if (w_err && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

    assign out_valid = w_valid;
    assign out_data  = w_data;
    assign out_sop   = w_sop;
    assign out_eop   = w_eop;
    assign err       = w_err;
    // The head word already shows its own source; later words use the latched value.
    assign out_src   = w_sop ? w_head[27:24] : r_src;
    assign pkt_cnt   = r_pkt_cnt;
    assign err_cnt   = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ni_flit_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_ni_flit_rx
// Description : Self-checking bench for ni_flit_rx: cycle-exact vector table,
//               hand sequences for saturation/source, and a randomized run
//               checked against a packet-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ni_flit_rx;

    localparam int         DEPTH   = 4;
    localparam logic [3:0] NODE_ID = 4'd4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [33:0] in_flit = '0;
    logic        in_req = 1'b0;
    logic        out_ack;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_sop;
    logic        out_eop;
    logic [3:0]  out_src;
    logic [15:0] pkt_cnt;
    logic [7:0]  err_cnt;
    logic        err;

    ni_flit_rx #(.DEPTH(DEPTH), .NODE_ID(NODE_ID)) dut (
        .clk(clk), .rst(rst), .in_flit(in_flit), .in_req(in_req),
        .out_ack(out_ack), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_sop(out_sop), .out_eop(out_eop),
        .out_src(out_src), .pkt_cnt(pkt_cnt), .err_cnt(err_cnt), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rst, req, ready;
        logic [33:0] flit;
        logic        ack, valid;
        logic [31:0] data;
        logic        sop, eop, errp;
        logic [15:0] pkt;
        logic [7:0]  errc;
    } vec_t;
    vec_t vq[$];

    task automatic add(input logic r, input logic q, input logic rd, input logic [33:0] f,
                       input logic a, input logic v, input logic [31:0] d,
                       input logic s, input logic e, input logic ep,
                       input logic [15:0] p, input logic [7:0] ec);
        vec_t x;
        x.rst = r; x.req = q; x.ready = rd; x.flit = f;
        x.ack = a; x.valid = v; x.data = d; x.sop = s; x.eop = e; x.errp = ep;
        x.pkt = p; x.errc = ec;
        vq.push_back(x);
    endtask

    // ---------------- packet-level reference model ----------------
    typedef struct {
        logic [31:0] data;
        logic        sop, eop;
        logic [3:0]  src;
    } word_t;
    word_t exp_q[$];
    localparam int M_IDLE = 0, M_PKT = 1, M_DROP = 2;
    int         m_state;
    logic [3:0] m_src;
    int         m_err, m_pkt, err_seen;

    task automatic emit(input logic [31:0] d, input logic s, input logic e, input logic [3:0] sr);
        word_t w;
        w.data = d; w.sop = s; w.eop = e; w.src = sr;
        exp_q.push_back(w);
        if (e) m_pkt++;
    endtask

    task automatic model_push(input logic [33:0] f);
        logic [1:0] ty;
        logic       hit;
        bit         again;
        bit         quiet;
        ty  = f[33:32];
        hit = (f[31:28] == NODE_ID);
        do begin
            again = 0;
            if (m_state == M_PKT) begin
                if (ty == 2'b00 || ty == 2'b01) begin
                    emit(f[31:0], 1'b0, ty == 2'b01, m_src);
                    if (ty == 2'b01) m_state = M_IDLE;
                end else begin
                    emit(32'h0, 1'b0, 1'b1, m_src);
                    m_err++;
                    m_state = M_IDLE;
                    again = 1;
                end
            end else begin
                quiet = (m_state == M_DROP);
                if (ty[1]) begin
                    if (hit) begin
                        m_src = f[27:24];
                        emit(f[31:0], 1'b1, ty == 2'b11, m_src);
                        m_state = (ty == 2'b11) ? M_IDLE : M_PKT;
                    end else begin
                        if (!quiet) m_err++;
                        m_state = (ty == 2'b10) ? M_DROP : M_IDLE;
                    end
                end else begin
                    if (!quiet) m_err++;
                    if (ty == 2'b01) m_state = M_IDLE;
                end
            end
        end while (again);
    endtask

    function automatic logic [33:0] rand_flit();
        logic [31:0] p;
        logic [1:0]  ty;
        int          r;
        p = $urandom;
        r = $urandom_range(0, 15);
        ty = (r < 3) ? 2'b10 : (r < 10) ? 2'b00 : (r < 13) ? 2'b01 : 2'b11;
        if ($urandom_range(0, 5) != 0) p[31:28] = NODE_ID;
        return {ty, p};
    endfunction

    // ---------------- monitor for the randomized phase ----------------
    bit          mon_en = 0;
    bit          accepted = 0;
    bit          stall_prev = 0;
    logic [33:0] prev_out;

    always @(negedge clk) begin
        if (mon_en) begin
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL word_extra got data=%h sop=%b eop=%b, expected no word", out_data, out_sop, out_eop);
                end else begin
                    word_t e;
                    e = exp_q.pop_front();
                    if ({out_data, out_sop, out_eop, out_src} !== {e.data, e.sop, e.eop, e.src}) begin
                        errors++;
                        $display("FAIL word got data=%h sop=%b eop=%b src=%h expected data=%h sop=%b eop=%b src=%h",
                                 out_data, out_sop, out_eop, out_src, e.data, e.sop, e.eop, e.src);
                    end
                end
            end
            if (stall_prev) begin
                checks++;
                if (!out_valid || {out_data, out_sop, out_eop} !== prev_out) begin
                    errors++;
                    $display("FAIL stall_stable got valid=%b %h expected valid=1 %h",
                             out_valid, {out_data, out_sop, out_eop}, prev_out);
                end
            end
            stall_prev = out_valid && !out_ready;
            prev_out   = {out_data, out_sop, out_eop};
            if (err) err_seen++;
            accepted = in_req && out_ack;
            if (accepted) model_push(in_flit);
        end
    end

    // ---------------- main sequence ----------------
    logic [60:0] got, want;
    int          n_err, n_val, cyc;
    bit          seen;

    initial begin
        // Cycle-exact vectors: rst req ready flit | ack valid data sop eop err pkt_cnt err_cnt
        add(0,1,1,{2'b11,32'h4A000055}, 1,0,32'h0,0,0,0, 0,0);
        add(0,1,1,{2'b10,32'h4B000001}, 1,1,32'h4A000055,1,1,0, 0,0);
        add(0,1,1,{2'b00,32'h11111111}, 1,1,32'h4B000001,1,0,0, 1,0);
        add(0,1,1,{2'b00,32'h22222222}, 1,1,32'h11111111,0,0,0, 1,0);
        add(0,1,1,{2'b01,32'h33333333}, 1,1,32'h22222222,0,0,0, 1,0);
        add(0,0,1,34'h0,                1,1,32'h33333333,0,1,0, 1,0);
        add(0,0,1,34'h0,                1,0,32'h0,0,0,0, 2,0);
        // backpressure: six flits offered into a four-entry FIFO
        add(0,1,0,{2'b10,32'h4C000010}, 1,0,32'h0,0,0,0, 2,0);
        add(0,1,0,{2'b00,32'h00000011}, 1,1,32'h4C000010,1,0,0, 2,0);
        add(0,1,0,{2'b00,32'h00000012}, 1,1,32'h4C000010,1,0,0, 2,0);
        add(0,1,0,{2'b00,32'h00000013}, 1,1,32'h4C000010,1,0,0, 2,0);
        add(0,1,0,{2'b00,32'h00000014}, 0,1,32'h4C000010,1,0,0, 2,0);
        add(0,1,1,{2'b00,32'h00000014}, 0,1,32'h4C000010,1,0,0, 2,0);
        add(0,1,1,{2'b00,32'h00000014}, 1,1,32'h00000011,0,0,0, 2,0);
        add(0,1,1,{2'b01,32'h00000015}, 1,1,32'h00000012,0,0,0, 2,0);
        add(0,0,1,34'h0,                1,1,32'h00000013,0,0,0, 2,0);
        add(0,0,1,34'h0,                1,1,32'h00000014,0,0,0, 2,0);
        add(0,0,1,34'h0,                1,1,32'h00000015,0,1,0, 2,0);
        add(0,0,1,34'h0,                1,0,32'h0,0,0,0, 3,0);
        // wrong destination packet, then a good single
        add(0,1,1,{2'b10,32'h35000000}, 1,0,32'h0,0,0,0, 3,0);
        add(0,1,1,{2'b00,32'h00000001}, 1,0,32'h0,0,0,1, 3,0);
        add(0,1,1,{2'b01,32'h00000002}, 1,0,32'h0,0,0,0, 3,1);
        add(0,1,1,{2'b11,32'h46000077}, 1,0,32'h0,0,0,0, 3,1);
        add(0,0,1,34'h0,                1,1,32'h46000077,1,1,0, 3,1);
        add(0,0,1,34'h0,                1,0,32'h0,0,0,0, 4,1);
        // missing tail: head, body, new head
        add(0,1,1,{2'b10,32'h47000001}, 1,0,32'h0,0,0,0, 4,1);
        add(0,1,1,{2'b00,32'h000000AA}, 1,1,32'h47000001,1,0,0, 4,1);
        add(0,1,1,{2'b10,32'h48000002}, 1,1,32'h000000AA,0,0,0, 4,1);
        add(0,1,1,{2'b01,32'h000000BB}, 1,1,32'h00000000,0,1,1, 4,1);
        add(0,0,1,34'h0,                1,1,32'h48000002,1,0,0, 5,2);
        add(0,0,1,34'h0,                1,1,32'h000000BB,0,1,0, 5,2);
        add(0,0,1,34'h0,                1,0,32'h0,0,0,0, 6,2);
        // reset with two flits buffered mid-packet
        add(0,1,0,{2'b10,32'h49000000}, 1,0,32'h0,0,0,0, 6,2);
        add(0,1,0,{2'b00,32'h00000000}, 1,1,32'h49000000,1,0,0, 6,2);
        add(1,0,0,34'h0,                0,0,32'h0,0,0,0, 6,2);
        add(0,0,0,34'h0,                1,0,32'h0,0,0,0, 0,0);

        repeat (3) @(posedge clk);
        for (int i = 0; i < vq.size(); i++) begin
            @(posedge clk); #1;
            rst = vq[i].rst; in_req = vq[i].req; in_flit = vq[i].flit; out_ready = vq[i].ready;
            @(negedge clk);
            got  = {out_ack, out_valid, out_data, out_sop, out_eop, err, pkt_cnt, err_cnt};
            want = {vq[i].ack, vq[i].valid, vq[i].data, vq[i].sop, vq[i].eop, vq[i].errp, vq[i].pkt, vq[i].errc};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL vec%0d got ack/valid/data/sop/eop/err/pkt/errc=%h expected %h", i, got, want);
            end
        end
        checks++;
        if (out_src !== 4'h0) begin
            errors++;
            $display("FAIL src_after_reset got %h expected 0", out_src);
        end

        // err_cnt saturation: 260 stray body flits in IDLE
        n_err = 0; n_val = 0;
        for (int c = 0; c < 263; c++) begin
            @(posedge clk); #1;
            in_req = (c < 260); in_flit = {2'b00, 32'h0000_0100 + c}; out_ready = 1'b1;
            @(negedge clk);
            if (err) n_err++;
            if (out_valid) n_val++;
        end
        checks++;
        if (n_err != 260 || n_val != 0) begin
            errors++;
            $display("FAIL sat_pulses got err=%0d valid=%0d expected err=260 valid=0", n_err, n_val);
        end
        checks++;
        if (err_cnt !== 8'd255 || pkt_cnt !== 16'd0) begin
            errors++;
            $display("FAIL sat_count got err_cnt=%0d pkt_cnt=%0d expected 255 0", err_cnt, pkt_cnt);
        end

        // single flit: source reported with the word and retained afterwards
        @(posedge clk); #1;
        in_req = 1'b1; in_flit = {2'b11, 32'h4A000055}; out_ready = 1'b0;
        @(posedge clk); #1;
        in_req = 1'b0;
        seen = 0;
        for (cyc = 0; cyc < 10 && !seen; cyc++) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        checks++;
        if (!seen || {out_data, out_sop, out_eop, out_src} !== {32'h4A000055, 1'b1, 1'b1, 4'hA}) begin
            errors++;
            $display("FAIL single_word got valid=%b data=%h sop=%b eop=%b src=%h expected data=4a000055 sop=1 eop=1 src=a",
                     out_valid, out_data, out_sop, out_eop, out_src);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (pkt_cnt !== 16'd1 || out_src !== 4'hA || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_after got pkt_cnt=%0d src=%h valid=%b expected 1 a 0", pkt_cnt, out_src, out_valid);
        end

        // randomized run against the reference model
        @(posedge clk); #1;
        rst = 1'b1; in_req = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        m_state = M_IDLE; m_src = '0; m_err = 0; m_pkt = 0; err_seen = 0;
        accepted = 0; stall_prev = 0;
        mon_en = 1;
        for (int c = 0; c < 3000; c++) begin
            if (!in_req || accepted) begin
                in_req  = ($urandom_range(0, 3) != 0);
                in_flit = rand_flit();
            end
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        in_req = 1'b0; out_ready = 1'b1;
        repeat (40) @(posedge clk);
        @(negedge clk);
        #1 mon_en = 0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL rand_drain got %0d words undelivered expected 0", exp_q.size());
        end
        checks++;
        if (pkt_cnt !== 16'(m_pkt)) begin
            errors++;
            $display("FAIL rand_pkt_cnt got %0d expected %0d", pkt_cnt, 16'(m_pkt));
        end
        checks++;
        if (err_cnt !== 8'((m_err > 255) ? 255 : m_err) || err_seen != m_err) begin
            errors++;
            $display("FAIL rand_err got err_cnt=%0d pulses=%0d expected err_cnt=%0d pulses=%0d",
                     err_cnt, err_seen, (m_err > 255) ? 255 : m_err, m_err);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
